// File: rtl/pattern_pulse_gen.sv
// rtl/pattern_pulse_gen.sv - serialises a WIDTH-bit pattern onto one pulse line with per-bit hold time
module pattern_pulse_gen #(
    parameter int WIDTH     = 8,
    parameter int DIV_W     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic [DIV_W-1:0] div,
    input  logic             repeat_mode,
    input  logic             stop,
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pattern, pattern_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [DIV_W-1:0] prescnt, prescnt_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic             pulse_n, busy_n, done_n;

    // Bit that leaves the shift register first, depending on emission order
    function automatic logic first_bit(input logic [WIDTH-1:0] p);
        return LSB_FIRST ? p[0] : p[WIDTH-1];
    endfunction

    // Moves the next bit to be emitted into the front position
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] p);
        return LSB_FIRST ? (p >> 1) : (p << 1);
    endfunction

    // State register
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) state <= IDLE;
        else     state <= state_n;
    end

    // Datapath and output registers; pulse/busy/done are registered outputs
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pattern <= '0;
            shreg   <= '0;
            div_q   <= '0;
            prescnt <= '0;
            bitcnt  <= '0;
            pulse   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            pattern <= pattern_n;
            shreg   <= shreg_n;
            div_q   <= div_n;
            prescnt <= prescnt_n;
            bitcnt  <= bitcnt_n;
            pulse   <= pulse_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state logic: load/abort in IDLE, prescaled bit stepping and frame end in SHIFT
    always_comb begin
        state_n   = state;
        pattern_n = pattern;
        shreg_n   = shreg;
        div_n     = div_q;
        prescnt_n = prescnt;
        bitcnt_n  = bitcnt;
        pulse_n   = pulse;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                // stop outranks a simultaneous load
                if (load && !stop) begin
                    state_n   = SHIFT;
                    pattern_n = value;
                    shreg_n   = value;
                    div_n     = div;
                    prescnt_n = div;
                    bitcnt_n  = '0;
                    pulse_n   = first_bit(value);
                    busy_n    = 1'b1;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_n = IDLE;
                    pulse_n = 1'b0;
                    busy_n  = 1'b0;
                end else if (prescnt != '0) begin
                    prescnt_n = prescnt - 1'b1;
                end else begin
                    prescnt_n = div_q;
                    if (bitcnt == LAST) begin
                        bitcnt_n = '0;
                        if (repeat_mode) begin
                            // restart from the captured pattern with no gap cycle
                            shreg_n = pattern;
                            pulse_n = first_bit(pattern);
                        end else begin
                            state_n = IDLE;
                            pulse_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                        shreg_n  = advance(shreg);
                        pulse_n  = first_bit(advance(shreg));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pattern_pulse_gen.sv
// tb/tb_pattern_pulse_gen.sv - scoreboard bench for pattern_pulse_gen (8-bit MSB-first and 5-bit LSB-first)
module tb_pattern_pulse_gen;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       load = 1'b0;
    logic [7:0] value = '0;
    logic [3:0] div = '0;
    logic       rpt = 1'b0;
    logic       stop = 1'b0;
    logic       pulse0, busy0, done0;
    logic       pulse1, busy1, done1;
    logic [4:0] value5;

    int n_checks = 0;
    int n_fail   = 0;

    assign value5 = value[4:0];

    always #5 Clk = ~Clk;

    pattern_pulse_gen #(.WIDTH(8), .DIV_W(4), .LSB_FIRST(1'b0)) dut8 (
        .Clk(Clk), .Clr(Clr), .load(load), .value(value), .div(div),
        .repeat_mode(rpt), .stop(stop), .pulse(pulse0), .busy(busy0), .done(done0)
    );

    pattern_pulse_gen #(.WIDTH(5), .DIV_W(4), .LSB_FIRST(1'b1)) dut5 (
        .Clk(Clk), .Clr(Clr), .load(load), .value(value5), .div(div),
        .repeat_mode(rpt), .stop(stop), .pulse(pulse1), .busy(busy1), .done(done1)
    );

    // Reference model: a frame is a start time plus pattern/div; output is arithmetic on elapsed cycles
    int         mw[2]   = '{8, 5};
    bit         mlsb[2] = '{1'b0, 1'b1};
    bit         m_act[2];
    bit         m_done[2];
    logic [7:0] m_pat[2];
    int         m_div[2];
    int         m_t[2];

    logic [2:0] q0[$];
    logic [2:0] q1[$];

    function automatic bit bit_at(int k, int i);
        logic [7:0] p;
        p = m_pat[k];
        return mlsb[k] ? p[i] : p[mw[k] - 1 - i];
    endfunction

    function automatic logic [2:0] model_out(int k);
        bit p;
        p = m_act[k] ? bit_at(k, m_t[k] / (m_div[k] + 1)) : 1'b0;
        return {p, m_act[k], m_done[k]};
    endfunction

    task automatic model_edge(int k);
        m_done[k] = 1'b0;
        if (!m_act[k]) begin
            if (load && !stop) begin
                m_act[k] = 1'b1;
                m_pat[k] = (k == 0) ? value : {3'b000, value[4:0]};
                m_div[k] = int'(div);
                m_t[k]   = 0;
            end
        end else if (stop) begin
            m_act[k] = 1'b0;
        end else begin
            m_t[k]++;
            if (m_t[k] == mw[k] * (m_div[k] + 1)) begin
                if (rpt) m_t[k] = 0;
                else begin
                    m_act[k]  = 1'b0;
                    m_done[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k]  = 1'b0;
            m_done[k] = 1'b0;
            m_t[k]    = 0;
        end
    endtask

    task automatic check(string name, logic [2:0] act, logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got pulse/busy/done=%b required %b", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then let the edge happen
    task automatic cyc(bit l, logic [7:0] v, logic [3:0] d, bit r, bit s);
        load  = l;
        value = v;
        div   = d;
        rpt   = r;
        stop  = s;
        model_edge(0);
        model_edge(1);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(int n, bit r = 1'b0);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 4'd0, r, 1'b0);
    endtask

    // Monitor: every cycle where a prediction is pending, compare it with what the DUTs show
    always @(negedge Clk) begin
        if (q0.size() > 0) check("dut8_out", {pulse0, busy0, done0}, q0.pop_front());
        if (q1.size() > 0) check("dut5_out", {pulse1, busy1, done1}, q1.pop_front());
    end

    initial begin
        model_reset();
        #2;
        check("reset8", {pulse0, busy0, done0}, 3'b000);
        check("reset5", {pulse1, busy1, done1}, 3'b000);
        @(negedge Clk);
        Clr = 1'b0;
        #1;

        // T1: Clr mid-frame, then a fresh C3 frame
        cyc(1'b1, 8'hC3, 4'd0, 1'b0, 1'b0);
        idle(3);
        @(negedge Clk);
        #1;
        Clr = 1'b1;
        #1;
        check("midreset8", {pulse0, busy0, done0}, 3'b000);
        check("midreset5", {pulse1, busy1, done1}, 3'b000);
        model_reset();
        #1;
        Clr = 1'b0;
        cyc(1'b1, 8'hC3, 4'd0, 1'b0, 1'b0);
        idle(10);

        // T2: one-shot
        cyc(1'b1, 8'b1011_0001, 4'd0, 1'b0, 1'b0);
        idle(10);

        // T3: prescale div=2
        cyc(1'b1, 8'h80, 4'd2, 1'b0, 1'b0);
        idle(27);

        // div all-ones: 16 cycles per bit
        cyc(1'b1, 8'h81, 4'hF, 1'b0, 1'b0);
        idle(8 * 16 + 2);

        // T4: repeat, then drop repeat mid-frame
        cyc(1'b1, 8'hA5, 4'd0, 1'b1, 1'b0);
        idle(20, 1'b1);
        idle(12);

        // T5: load during busy ignored, stop at bit 3, stop+load in IDLE
        cyc(1'b1, 8'h5A, 4'd0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 8'hFF, 4'd0, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b1, 8'hFF, 4'd0, 1'b0, 1'b1);
        idle(3);

        // T6: value 00011, then reload in the 5-bit unit's done cycle
        cyc(1'b1, 8'h03, 4'd0, 1'b0, 1'b0);
        idle(5);
        cyc(1'b1, 8'h03, 4'd0, 1'b0, 1'b0);
        idle(12);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit         l, r, s;
            logic [7:0] v;
            logic [3:0] d;
            l = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 40) == 0);
            r = ($urandom_range(0, 3) == 0);
            v = 8'($urandom);
            d = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            cyc(l, v, d, r, s);
        end
        idle(4);

        @(negedge Clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
